seg7_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler that shares one external hex-to-7-segment decoder among
//  NUM_DIGITS common-cathode digits. Accepts a packed hex value via valid/ready handshake,

---
 rtl/seg7_scan_ctrl.sv | 105 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Digit-scan scheduler for a shared hex-to-7-seg decoder; outputs registered from next-state counters (zero lag vs cnt/idx).
// in_valid/in_ready: one-entry pending buffer, committed at frame boundary. Define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    output logic                    in_ready,
    input  logic                    disp_on,
    output logic [3:0]              digit_hex,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_tick
);

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pending_full;
    logic [3:0]              r_digit_hex;
    logic [NUM_DIGITS-1:0]   r_dig_en;
    logic                    r_frame_tick;

    logic [CW-1:0]           w_cnt_nxt;
    logic [IW-1:0]           w_idx_nxt;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_commit;
    logic                    w_xfer;
    logic [4*NUM_DIGITS-1:0] w_active_nxt;
    logic [0:0]              w_phase_nxt;
    logic [NUM_DIGITS-1:0]   w_show;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_nz;

    assign w_slot_end   = (r_cnt == CNT_MAX);
    assign w_frame_end  = w_slot_end && (r_idx == IDX_MAX);
    assign w_commit     = w_frame_end && r_pending_full;
    assign w_xfer       = in_valid && !r_pending_full;
    assign w_cnt_nxt    = w_slot_end ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt    = !w_slot_end ? r_idx : ((r_idx == IDX_MAX) ? '0 : r_idx + 1'b1);
    assign w_active_nxt = w_commit ? r_pending : r_active;
    assign w_phase_nxt  = (w_cnt_nxt < BLANK_END) ? ST_BLANK : ST_SHOW;
    assign w_onehot     = NUM_DIGITS'(1) << w_idx_nxt;

`ifdef SEG7_SCAN_LZB_EN
    // Scan from the most significant digit down: a digit is shown once any nibble at or above it is non-zero.
    always_comb begin
        w_show = '0;
        w_nz   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_nz      = w_nz | (|w_active_nxt[4*i +: 4]);
            w_show[i] = w_nz || (i == 0);
        end
    end
`else
    assign w_show = '1;
    assign w_nz   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_active       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_digit_hex    <= '0;
            r_dig_en       <= '0;
            r_frame_tick   <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_active     <= w_active_nxt;
            r_frame_tick <= w_frame_end;
            r_digit_hex  <= w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
            r_dig_en     <= (w_phase_nxt == ST_SHOW && disp_on && w_show[w_idx_nxt]) ? w_onehot : '0;
            if (w_xfer) begin
                r_pending      <= in_data;
                r_pending_full <= 1'b1;
            end else if (w_commit) begin
                r_pending_full <= 1'b0;
            end
        end
    end

    assign in_ready   = !r_pending_full;
    assign digit_hex  = r_digit_hex;
    assign dig_en     = r_dig_en;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised and directed bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 dark cycles).
// Reference model tracks elapsed cycles since reset and derives slot/digit/frame arithmetically.
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int DW = 8;
    localparam int BL = 2;
    localparam int FR = ND * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = '0;
    logic          in_ready;
    logic          disp_on = 1'b1;
    logic [3:0]    digit_hex;
    logic [ND-1:0] dig_en;
    logic          frame_tick;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .disp_on(disp_on), .digit_hex(digit_hex), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int          t;
    logic [15:0] m_active, m_pending;
    bit          m_full, m_tick, m_disp, m_xfer;

    function automatic bit shown(int idx);
`ifdef SEG7_SCAN_LZB_EN
        return (idx == 0) || ((m_active >> (4 * idx)) != 0);
`else
        return 1'b1;
`endif
    endfunction

    // {in_ready, frame_tick, digit_hex, dig_en}
    function automatic logic [9:0] exp_vec();
        int idx, cnt;
        logic [3:0] en;
        idx = (t / DW) % ND;
        cnt = t % DW;
        en = '0;
        if (cnt >= BL && m_disp && shown(idx)) en = 4'(1 << idx);
        return {!m_full, m_tick, 4'((m_active >> (4 * idx)) & 16'hF), en};
    endfunction

    task automatic step();
        bit commit_c;
        @(posedge clk);
        if (!rst_n) begin
            t = 0; m_active = '0; m_full = 0; m_tick = 0; m_disp = 0; m_xfer = 0;
        end else begin
            commit_c = (t % FR) == FR - 1;
            m_xfer   = in_valid && !m_full;
            if (commit_c && m_full) begin m_active = m_pending; m_full = 0; end
            if (m_xfer) begin m_pending = in_data; m_full = 1; end
            m_tick = commit_c;
            m_disp = disp_on;
            t++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; disp_on = 1'b1;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({in_ready, frame_tick, digit_hex, dig_en} !== 10'b10_0000_0000) begin
            n_err++; $display("FAIL reset_values got=%b want=%b", {in_ready, frame_tick, digit_hex, dig_en}, 10'b10_0000_0000);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (dig_en !== ((c + 1) % DW < BL ? 4'b0000 : 4'b0001) || digit_hex !== 4'h0) begin
                n_err++; $display("FAIL first_slot c=%0d dig_en=%b hex=%h", c + 1, dig_en, digit_hex);
            end
        end
    endtask

    task automatic test_free_run();
        int ticks = 0;
        for (int c = 0; c < 2 * FR; c++) begin
            step();
            ticks += frame_tick;
            n_cmp++;
            if ({in_ready, frame_tick, digit_hex, dig_en} !== exp_vec()) begin
                n_err++; $display("FAIL free_run t=%0d got=%b want=%b", t, {in_ready, frame_tick, digit_hex, dig_en}, exp_vec());
            end
        end
        n_cmp++;
        if (ticks != 2) begin n_err++; $display("FAIL free_run_ticks got=%0d want=2", ticks); end
    endtask

    task automatic test_load();
        do_reset();
        for (int c = 0; c < 5; c++) step();
        in_valid = 1'b1; in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_low got=%b want=0", in_ready); end
        for (int c = 0; c < 2 * FR; c++) begin
            step();
            n_cmp++;
            if ({in_ready, frame_tick, digit_hex, dig_en} !== exp_vec()) begin
                n_err++; $display("FAIL load t=%0d got=%b want=%b", t, {in_ready, frame_tick, digit_hex, dig_en}, exp_vec());
            end
            if (t == FR + 3 * DW) begin
                n_cmp++;
                if (digit_hex !== 4'h1) begin n_err++; $display("FAIL load_digit3 got=%h want=1", digit_hex); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ready_wait = -1;
        do_reset();
        in_valid = 1'b1; in_data = 16'hAAAA;
        step();
        in_data = 16'h5555;
        for (int c = 0; c < 3 * FR; c++) begin
            step();
            if (m_xfer) in_valid = 1'b0;
            if (m_xfer && ready_wait < 0) ready_wait = t;
            n_cmp++;
            if ({in_ready, frame_tick, digit_hex, dig_en} !== exp_vec()) begin
                n_err++; $display("FAIL b2b t=%0d got=%b want=%b", t, {in_ready, frame_tick, digit_hex, dig_en}, exp_vec());
            end
        end
        in_valid = 1'b0;
        // 5555 can only enter once AAAA is committed at t=FR
        n_cmp++;
        if (ready_wait != FR + 1) begin n_err++; $display("FAIL b2b_accept_time got=%0d want=%0d", ready_wait, FR + 1); end
    endtask

    task automatic test_disp_off();
        int ticks = 0;
        disp_on = 1'b0;
        for (int c = 0; c < FR; c++) begin
            step();
            ticks += frame_tick;
            n_cmp++;
            if (dig_en !== 4'b0 || digit_hex !== exp_vec()[7:4]) begin
                n_err++; $display("FAIL disp_off t=%0d dig_en=%b hex=%h want_hex=%h", t, dig_en, digit_hex, exp_vec()[7:4]);
            end
        end
        disp_on = 1'b1;
        n_cmp++;
        if (ticks != 1) begin n_err++; $display("FAIL disp_off_ticks got=%0d want=1", ticks); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 16'h9876;
        step();
        in_valid = 1'b0;
        while (t % DW < BL + 1) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({in_ready, frame_tick, digit_hex, dig_en} !== 10'b10_0000_0000) begin
            n_err++; $display("FAIL reset_mid got=%b want=%b", {in_ready, frame_tick, digit_hex, dig_en}, 10'b10_0000_0000);
        end
        for (int c = 0; c < FR + 8; c++) begin
            step();
            n_cmp++;
            if (digit_hex !== 4'h0) begin n_err++; $display("FAIL reset_mid_stale t=%0d got=%h want=0", t, digit_hex); end
        end
    endtask

    task automatic test_lzb(input logic [15:0] val, input logic [3:0] want_lit);
        logic [3:0] lit = '0;
        in_valid = 1'b1; in_data = val;
        step();
        in_valid = 1'b0;
        while (t % FR != 0) step();
        for (int c = 0; c < FR; c++) begin
            lit |= dig_en;
            n_cmp++;
            if ({in_ready, frame_tick, digit_hex, dig_en} !== exp_vec()) begin
                n_err++; $display("FAIL lzb t=%0d got=%b want=%b", t, {in_ready, frame_tick, digit_hex, dig_en}, exp_vec());
            end
            step();
        end
        n_cmp++;
        if (lit !== want_lit) begin n_err++; $display("FAIL lzb_lit val=%h got=%b want=%b", val, lit, want_lit); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) in_data[15:8] = '0;
            disp_on  = ($urandom_range(0, 7) != 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            step();
            n_cmp++;
            if ({in_ready, frame_tick, digit_hex, dig_en} !== exp_vec()) begin
                n_err++; $display("FAIL random t=%0d got=%b want=%b", t, {in_ready, frame_tick, digit_hex, dig_en}, exp_vec());
            end
        end
        rst_n = 1'b1; in_valid = 1'b0; disp_on = 1'b1;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_load();
        test_back_to_back();
        test_disp_off();
        test_reset_mid();
`ifdef SEG7_SCAN_LZB_EN
        test_lzb(16'h0050, 4'b0011);
        test_lzb(16'h0000, 4'b0001);
`else
        test_lzb(16'h0050, 4'b1111);
        test_lzb(16'h0000, 4'b1111);
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
